// File: rtl/key_search_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : key_search_pkg                                               |
// | Description : Shared types and default widths for the RC4 key-search       |
// |               scheduler: key type, scheduler state encoding, defaults for  |
// |               key width and last searched key.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package key_search_pkg;

   localparam int unsigned            c_KEY_WIDTH = 24;
   localparam logic [c_KEY_WIDTH-1:0] c_KEY_LIMIT = 24'h3FFFFF;

   typedef logic [c_KEY_WIDTH-1:0] key_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DISPATCH  = 3'd1,
      DRAIN     = 3'd2,
      FOUND     = 3'd3,
      EXHAUSTED = 3'd4
   } sched_state_t;

endpackage : key_search_pkg
`default_nettype wire

// File: rtl/key_search_scheduler_rr_grant.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_grant                                                     |
// | Description : Combinational round-robin picker. Scans the request vector   |
// |               starting at ptr and grants the first requester (one-hot).    |
// | Ports       : req       in  NUM_REQ  requesting (idle) cores               |
// |               ptr       in  PTR_W    index scanned first                   |
// |               grant     out NUM_REQ  one-hot grant, zero when no request   |
// |               grant_idx out PTR_W    index of the granted requester        |
// |               grant_vld out 1        some requester was granted            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_grant #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx,
   output logic               grant_vld
);

   logic [PTR_W-1:0] w_idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      w_idx     = '0;
      // Visit requesters in rotated order ptr, ptr+1, ...; the first hit wins.
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
         if (!grant_vld && req[w_idx]) begin
            grant[w_idx] = 1'b1;
            grant_idx    = w_idx;
            grant_vld    = 1'b1;
         end
      end
   end

endmodule : rr_grant
`default_nettype wire

// File: rtl/key_search_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : key_search_scheduler                                         |
// | Description : Hands fixed-size RC4 key chunks to NUM_CORES decrypt cores,  |
// |               stops every core on the first hit, latches the winning key   |
// |               and flags exhaustion of the key range.                       |
// | Ports       : clock, reset (sync, active-high), start (pulse)              |
// |               busy / found / exhausted status, found_key, found_core       |
// |               core_start, core_key_lo, core_key_hi, core_abort -> cores    |
// |               core_done, core_hit, core_hit_key               <- cores     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module key_search_scheduler
   import key_search_pkg::*;
#(
   parameter  int unsigned          NUM_CORES  = 4,
   parameter  int unsigned          KEY_WIDTH  = c_KEY_WIDTH,
   parameter  logic [KEY_WIDTH-1:0] KEY_LIMIT  = c_KEY_LIMIT,
   parameter  int unsigned          CHUNK_LOG2 = 16,
   localparam int unsigned          IDX_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   output logic                           busy,
   output logic                           found,
   output logic                           exhausted,
   output logic [KEY_WIDTH-1:0]           found_key,
   output logic [IDX_W-1:0]               found_core,
   output logic [NUM_CORES-1:0]           core_start,
   output logic [NUM_CORES*KEY_WIDTH-1:0] core_key_lo,
   output logic [NUM_CORES*KEY_WIDTH-1:0] core_key_hi,
   output logic                           core_abort,
   input  logic [NUM_CORES-1:0]           core_done,
   input  logic [NUM_CORES-1:0]           core_hit,
   input  logic [NUM_CORES*KEY_WIDTH-1:0] core_hit_key
);

   // next_key carries one extra bit so stepping past the top of the key space
   // never wraps back to zero.
   localparam logic [KEY_WIDTH:0] ONE        = {{KEY_WIDTH{1'b0}}, 1'b1};
   localparam logic [KEY_WIDTH:0] CHUNK_SIZE = ONE << CHUNK_LOG2;
   localparam logic [KEY_WIDTH:0] CHUNK_LAST = CHUNK_SIZE - ONE;
   localparam logic [KEY_WIDTH:0] LIMIT_EXT  = {1'b0, KEY_LIMIT};

   sched_state_t                state_q, state_d;
   logic [KEY_WIDTH:0]          next_key_q, next_key_d;
   logic [NUM_CORES-1:0]        assigned_q, assigned_d;
   logic [IDX_W-1:0]            ptr_q, ptr_d;
   logic [KEY_WIDTH-1:0]        found_key_q, found_key_d;
   logic [IDX_W-1:0]            found_core_q, found_core_d;
   logic [NUM_CORES-1:0]        core_start_q, core_start_d;
   logic [KEY_WIDTH-1:0]        key_lo_q [NUM_CORES];
   logic [KEY_WIDTH-1:0]        key_lo_d [NUM_CORES];
   logic [KEY_WIDTH-1:0]        key_hi_q [NUM_CORES];
   logic [KEY_WIDTH-1:0]        key_hi_d [NUM_CORES];

   logic [KEY_WIDTH-1:0]        w_hit_key [NUM_CORES];
   logic [NUM_CORES-1:0]        w_hit_vec;
   logic [IDX_W-1:0]            w_hit_idx;
   logic [KEY_WIDTH-1:0]        w_hit_key_sel;
   logic [NUM_CORES-1:0]        w_grant;
   logic [IDX_W-1:0]            w_grant_idx;
   logic                        w_grant_vld;
   logic                        w_keys_left;
   logic [KEY_WIDTH:0]          w_chunk_end;
   logic [KEY_WIDTH-1:0]        w_chunk_hi;

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_core_if
      assign core_key_lo[i*KEY_WIDTH +: KEY_WIDTH] = key_lo_q[i];
      assign core_key_hi[i*KEY_WIDTH +: KEY_WIDTH] = key_hi_q[i];
      assign w_hit_key[i] = core_hit_key[i*KEY_WIDTH +: KEY_WIDTH];
   end

   // Only unassigned cores may be granted; a core finishing this cycle is
   // still marked assigned here, so it becomes grantable one edge later.
   rr_grant #(
      .NUM_REQ   (NUM_CORES)
   ) u_rr_grant (
      .req       (~assigned_q),
      .ptr       (ptr_q),
      .grant     (w_grant),
      .grant_idx (w_grant_idx),
      .grant_vld (w_grant_vld)
   );

   assign w_hit_vec   = core_done & core_hit;
   assign w_keys_left = (next_key_q <= LIMIT_EXT);
   assign w_chunk_end = next_key_q + CHUNK_LAST;
   // The chunk that straddles the limit is cut short at the limit.
   assign w_chunk_hi  = (w_chunk_end > LIMIT_EXT) ? KEY_LIMIT : w_chunk_end[KEY_WIDTH-1:0];

   // Lowest-index hit wins when several cores report a hit together.
   always_comb begin
      w_hit_idx     = '0;
      w_hit_key_sel = '0;
      for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
         if (w_hit_vec[i]) begin
            w_hit_idx     = IDX_W'(i);
            w_hit_key_sel = w_hit_key[i];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      next_key_d   = next_key_q;
      assigned_d   = assigned_q & ~core_done;
      ptr_d        = ptr_q;
      found_key_d  = found_key_q;
      found_core_d = found_core_q;
      core_start_d = '0;
      key_lo_d     = key_lo_q;
      key_hi_d     = key_hi_q;

      case (state_q)
         IDLE, FOUND, EXHAUSTED: begin
            if (start) begin
               state_d      = DISPATCH;
               next_key_d   = '0;
               found_key_d  = '0;
               found_core_d = '0;
            end
         end
         DISPATCH: begin
            if (|w_hit_vec) begin
               found_key_d  = w_hit_key_sel;
               found_core_d = w_hit_idx;
               state_d      = DRAIN;
            end else if (w_keys_left && w_grant_vld) begin
               core_start_d = w_grant;
               assigned_d   = assigned_d | w_grant;
               next_key_d   = next_key_q + CHUNK_SIZE;
               ptr_d        = (w_grant_idx == IDX_W'(NUM_CORES - 1)) ? '0 : w_grant_idx + 1'b1;
               for (int unsigned i = 0; i < NUM_CORES; i++) begin
                  if (w_grant[i]) begin
                     key_lo_d[i] = next_key_q[KEY_WIDTH-1:0];
                     key_hi_d[i] = w_chunk_hi;
                  end
               end
            end else if (!w_keys_left && (assigned_q == '0)) begin
               state_d = EXHAUSTED;
            end
         end
         DRAIN: begin
            if (assigned_q == '0) begin
               state_d = FOUND;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         next_key_q   <= '0;
         assigned_q   <= '0;
         ptr_q        <= '0;
         found_key_q  <= '0;
         found_core_q <= '0;
         core_start_q <= '0;
         for (int unsigned i = 0; i < NUM_CORES; i++) begin
            key_lo_q[i] <= '0;
            key_hi_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         next_key_q   <= next_key_d;
         assigned_q   <= assigned_d;
         ptr_q        <= ptr_d;
         found_key_q  <= found_key_d;
         found_core_q <= found_core_d;
         core_start_q <= core_start_d;
         key_lo_q     <= key_lo_d;
         key_hi_q     <= key_hi_d;
      end
   end

   assign busy       = (state_q == DISPATCH) || (state_q == DRAIN);
   assign core_abort = (state_q == DRAIN);
   assign found      = (state_q == FOUND);
   assign exhausted  = (state_q == EXHAUSTED);
   assign found_key  = found ? found_key_q  : '0;
   assign found_core = found ? found_core_q : '0;
   assign core_start = core_start_q;

endmodule : key_search_scheduler
`default_nettype wire
